// File: rtl/divider_freq_meter_pkg.sv
// Shared types and default sizing for the divided-clock frequency meter.
package divider_freq_meter_pkg;

  localparam int unsigned NCH_DEF    = 10;
  localparam int unsigned CNT_W_DEF  = 16;
  localparam int unsigned GATE_W_DEF = 16;
  localparam int unsigned SEL_W      = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LATCH   = 2'd2
  } state_e;

endpackage

// File: rtl/divider_freq_meter_chan.sv
// One measured channel: synchronizer, rising-edge detect and saturating edge counter.
module divider_freq_meter_chan
  import divider_freq_meter_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count_c,
  output logic             overflow_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1, s2, s3;
  logic             rise_c;
  logic [CNT_W-1:0] count;
  logic             overflow;

  assign rise_c = s2 & ~s3;

  // Synchronizer runs in every state so no stale edge shows up when a window opens.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      s3       <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      s1       <= sig;
      s2       <= s1;
      s3       <= s2;
      count    <= count_c;
      overflow <= overflow_c;
    end
  end

  // Next count is exported so the top can latch the final window edge without an extra cycle.
  always_comb begin
    count_c    = count;
    overflow_c = overflow;
    if (clr) begin
      count_c    = '0;
      overflow_c = 1'b0;
    end else if (en && rise_c) begin
      if (count == CNT_MAX) begin
        overflow_c = 1'b1;
      end else begin
        count_c = count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/divider_freq_meter.sv
// Gated edge counter for up to 16 divided clocks; latches per-channel counts and reads them by index.
module divider_freq_meter
  import divider_freq_meter_pkg::*;
#(
  parameter int unsigned NCH    = NCH_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF,
  parameter int unsigned GATE_W = GATE_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_cycles,
  input  logic [NCH-1:0]    sig_in,
  output logic              busy,
  output logic              done,
  input  logic [SEL_W-1:0]  rd_sel,
  output logic [CNT_W-1:0]  rd_count,
  output logic [NCH-1:0]    overflow
);

  state_e            state, state_nxt_c;
  logic [GATE_W-1:0] win, win_nxt_c;
  logic              clr_c, en_c, latch_c;
  logic [CNT_W-1:0]  cnt_c [NCH];
  logic [NCH-1:0]    ovf_c;
  logic [CNT_W-1:0]  result [NCH];
  logic [CNT_W-1:0]  rd_mux_c;

  for (genvar gi = 0; gi < int'(NCH); gi++) begin : g_chan
    divider_freq_meter_chan #(.CNT_W(CNT_W)) u_chan (
      .clk        (clk),
      .rst        (rst),
      .sig        (sig_in[gi]),
      .clr        (clr_c),
      .en         (en_c),
      .count_c    (cnt_c[gi]),
      .overflow_c (ovf_c[gi])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      win   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt_c;
      win   <= win_nxt_c;
      busy  <= (state_nxt_c == MEASURE);
      done  <= (state_nxt_c == LATCH);
    end
  end

  // Window runs exactly gate_cycles MEASURE cycles; a zero gate goes straight to LATCH.
  always_comb begin
    state_nxt_c = state;
    win_nxt_c   = win;
    clr_c       = 1'b0;
    en_c        = 1'b0;
    latch_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          clr_c       = 1'b1;
          win_nxt_c   = gate_cycles;
          state_nxt_c = (gate_cycles == '0) ? LATCH : MEASURE;
        end
      end
      MEASURE: begin
        en_c      = 1'b1;
        win_nxt_c = win - GATE_W'(1);
        if (win == GATE_W'(1)) begin
          state_nxt_c = LATCH;
        end
      end
      LATCH:   state_nxt_c = IDLE;
      default: state_nxt_c = IDLE;
    endcase
    latch_c = (state_nxt_c == LATCH);
  end

  always_comb begin
    rd_mux_c = '0;
    for (int i = 0; i < int'(NCH); i++) begin
      if (rd_sel == SEL_W'(i)) begin
        rd_mux_c = result[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NCH); i++) begin
        result[i] <= '0;
      end
      overflow <= '0;
      rd_count <= '0;
    end else begin
      if (latch_c) begin
        for (int i = 0; i < int'(NCH); i++) begin
          result[i] <= cnt_c[i];
        end
        overflow <= ovf_c;
      end
      rd_count <= rd_mux_c;
    end
  end

endmodule

// File: tb/tb_divider_freq_meter.sv
// Self-checking bench for divider_freq_meter: per-cycle input history scored by an edge-counting model.
module tb_divider_freq_meter;

  localparam int NCH  = 10;
  localparam int HIST = 8192;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] gate_cycles;
  logic [9:0]  sig_in;
  logic [3:0]  rd_sel;
  logic        busy, done, busy2, done2;
  logic [15:0] rd_count;
  logic [9:0]  overflow;
  logic [3:0]  rd_count2;
  logic [1:0]  overflow2;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic [9:0] hist [HIST];
  int   ratio [NCH];
  int   ph    [NCH];
  logic lvl   [NCH];

  divider_freq_meter dut (
    .clk(clk), .rst(rst), .start(start), .gate_cycles(gate_cycles), .sig_in(sig_in),
    .busy(busy), .done(done), .rd_sel(rd_sel), .rd_count(rd_count), .overflow(overflow)
  );

  divider_freq_meter #(.NCH(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .start(start), .gate_cycles(gate_cycles), .sig_in(sig_in[1:0]),
    .busy(busy2), .done(done2), .rd_sel(rd_sel), .rd_count(rd_count2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int ch = 0; ch < NCH; ch++) begin
      if (ratio[ch] == 0) sig_in[ch] = lvl[ch];
      else                sig_in[ch] = (((cyc + ph[ch]) % ratio[ch]) < (ratio[ch] / 2));
    end
    if (cyc < HIST) hist[cyc] = sig_in;
  endtask

  // Rising edges whose driven cycle k lies in [s-1, s+g-2] land inside the g-cycle window.
  function automatic int model_rises(int ch, int s, int g);
    int n = 0;
    for (int k = s - 1; k <= s + g - 2; k++) begin
      if (hist[k][ch] && !hist[k-1][ch]) n++;
    end
    return n;
  endfunction

  task automatic set_const(input logic v);
    for (int ch = 0; ch < NCH; ch++) begin
      ratio[ch] = 0;
      lvl[ch]   = v;
    end
  endtask

  task automatic launch(input int g, output int s);
    gate_cycles = 16'(g);
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int d);
    d = -1;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        d = cyc;
        break;
      end
      step();
    end
  endtask

  task automatic read_ch(input int ch, output logic [15:0] v, output logic [3:0] v2);
    rd_sel = 4'(ch);
    step();
    v  = rd_count;
    v2 = rd_count2;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; gate_cycles = '0; rd_sel = '0;
    set_const(1'b0);
    for (int ch = 0; ch < NCH; ch++) ph[ch] = 0;
    sig_in = '0;
    hist[0] = '0;
    repeat (3) step();
    total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0)      begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (rd_count !== 16'd0) begin bad++; $display("FAIL reset_rd_count got=%0d exp=0", rd_count); end
    total++; if (overflow !== 10'd0) begin bad++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    total++; if (rd_count2 !== 4'd0 || overflow2 !== 2'd0)
      begin bad++; $display("FAIL reset_dut2 got=%0d/%b exp=0/0", rd_count2, overflow2); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    int s, d; logic [15:0] v; logic [3:0] v2;
    ratio[0] = 4; ph[0] = int'($urandom_range(0, 3));
    repeat (8) step();
    launch(100, s);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", busy); end
    wait_done(150, d);
    total++; if (d != s + 101) begin bad++; $display("FAIL single_done_cycle got=%0d exp=%0d", d - s, 101); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_at_done got=%b exp=0", busy); end
    step();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL single_done_width got=%b exp=0", done); end
    read_ch(0, v, v2);
    total++; if (v !== 16'd25) begin bad++; $display("FAIL single_count got=%0d exp=25", v); end
    total++; if (int'(v) != model_rises(0, s, 100))
      begin bad++; $display("FAIL single_model got=%0d exp=%0d", v, model_rises(0, s, 100)); end
    total++; if (overflow[0] !== 1'b0) begin bad++; $display("FAIL single_ovf got=%b exp=0", overflow[0]); end
  endtask

  task automatic test_all_channels();
    int s, d, e; logic [15:0] v; logic [3:0] v2;
    for (int ch = 0; ch < NCH; ch++) begin
      ratio[ch] = 2 * (ch + 1);
      ph[ch]    = int'($urandom_range(0, 19));
    end
    repeat (25) step();
    launch(1000, s);
    wait_done(1100, d);
    total++; if (d != s + 1001) begin bad++; $display("FAIL all_done_cycle got=%0d exp=1001", d - s); end
    for (int ch = 0; ch < NCH; ch++) begin
      read_ch(ch, v, v2);
      e = model_rises(ch, s, 1000);
      total++; if (int'(v) != e) begin bad++; $display("FAIL all_ch%0d got=%0d exp=%0d", ch, v, e); end
      total++; if (int'(v) > 1000 / ratio[ch] + 1 || int'(v) < 1000 / ratio[ch] - 1)
        begin bad++; $display("FAIL all_ratio_ch%0d got=%0d exp=%0d+-1", ch, v, 1000 / ratio[ch]); end
    end
    read_ch(12, v, v2);
    total++; if (v !== 16'd0) begin bad++; $display("FAIL all_sel12 got=%0d exp=0", v); end
    read_ch(15, v, v2);
    total++; if (v !== 16'd0) begin bad++; $display("FAIL all_sel15 got=%0d exp=0", v); end
    total++; if (overflow !== 10'd0) begin bad++; $display("FAIL all_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_gate_zero();
    int s, d, nb; logic [15:0] v; logic [3:0] v2; logic [15:0] acc;
    nb = 0;
    launch(0, s);
    if (busy) nb++;
    wait_done(5, d);
    total++; if (d != s + 1) begin bad++; $display("FAIL zero_done_cycle got=%0d exp=1", d - s); end
    for (int i = 0; i < 4; i++) begin
      step();
      if (busy) nb++;
    end
    total++; if (nb != 0) begin bad++; $display("FAIL zero_busy got=%0d exp=0", nb); end
    acc = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      read_ch(ch, v, v2);
      acc |= v;
    end
    total++; if (acc !== 16'd0) begin bad++; $display("FAIL zero_counts got=%0d exp=0", acc); end
    total++; if (overflow !== 10'd0) begin bad++; $display("FAIL zero_ovf got=%b exp=0", overflow); end
  endtask

  task automatic test_saturate();
    int s, d, e; logic [15:0] v; logic [3:0] v2;
    ratio[0] = 2; ratio[1] = 2;
    repeat (5) step();
    launch(100, s);
    wait_done(150, d);
    read_ch(0, v, v2);
    e = model_rises(0, s, 100);
    total++; if (int'(v) != e) begin bad++; $display("FAIL sat_wide got=%0d exp=%0d", v, e); end
    total++; if (v2 !== 4'd15) begin bad++; $display("FAIL sat_count got=%0d exp=15", v2); end
    total++; if (overflow2[0] !== (e > 15)) begin bad++; $display("FAIL sat_ovf got=%b exp=%b", overflow2[0], e > 15); end
    launch(10, s);
    wait_done(30, d);
    read_ch(0, v, v2);
    e = model_rises(0, s, 10);
    total++; if (v2 !== 4'd5 || int'(v2) != e) begin bad++; $display("FAIL sat_rerun got=%0d exp=5", v2); end
    total++; if (overflow2[0] !== 1'b0) begin bad++; $display("FAIL sat_ovf_clear got=%b exp=0", overflow2[0]); end
  endtask

  task automatic test_start_ignored();
    int s, d, nd, e; logic [15:0] v; logic [3:0] v2;
    for (int ch = 0; ch < NCH; ch++) begin
      ratio[ch] = int'($urandom_range(2, 20));
      ph[ch]    = int'($urandom_range(0, 19));
    end
    repeat (5) step();
    launch(100, s);
    repeat (29) step();
    gate_cycles = 16'd7;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(120, d);
    total++; if (d != s + 101) begin bad++; $display("FAIL ign_done_cycle got=%0d exp=101", d - s); end
    start = 1'b1;
    step();
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ign_latch_start got=%b exp=0", busy); end
    nd = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) nd++;
      step();
    end
    total++; if (nd != 0) begin bad++; $display("FAIL ign_extra_done got=%0d exp=0", nd); end
    for (int ch = 0; ch < 4; ch++) begin
      read_ch(ch, v, v2);
      e = model_rises(ch, s, 100);
      total++; if (int'(v) != e) begin bad++; $display("FAIL ign_ch%0d got=%0d exp=%0d", ch, v, e); end
    end
  endtask

  task automatic test_reset_abort();
    int s, nd; logic [15:0] v; logic [3:0] v2; logic [15:0] acc;
    launch(100, s);
    repeat (49) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 110; i++) begin
      if (done) nd++;
      step();
    end
    total++; if (nd != 0) begin bad++; $display("FAIL abort_done got=%0d exp=0", nd); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b exp=0", busy); end
    total++; if (overflow !== 10'd0) begin bad++; $display("FAIL abort_ovf got=%b exp=0", overflow); end
    acc = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      read_ch(ch, v, v2);
      acc |= v;
    end
    total++; if (acc !== 16'd0) begin bad++; $display("FAIL abort_results got=%0d exp=0", acc); end
  endtask

  task automatic test_static();
    int s, d; logic [15:0] v; logic [3:0] v2; logic [15:0] acc;
    for (int ch = 0; ch < NCH; ch++) begin
      ratio[ch] = 0;
      lvl[ch]   = (ch < 5);
    end
    repeat (6) step();
    launch(50, s);
    wait_done(70, d);
    acc = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      read_ch(ch, v, v2);
      acc |= v;
    end
    total++; if (acc !== 16'd0) begin bad++; $display("FAIL static_counts got=%0d exp=0", acc); end
    set_const(1'b0);
    repeat (6) step();
    lvl[0] = 1'b1;
    repeat (3) step();
    launch(20, s);
    repeat (5) step();
    lvl[1] = 1'b1;
    wait_done(40, d);
    read_ch(0, v, v2);
    total++; if (v !== 16'd0 || int'(v) != model_rises(0, s, 20))
      begin bad++; $display("FAIL pre_edge got=%0d exp=0", v); end
    read_ch(1, v, v2);
    total++; if (v !== 16'd1 || int'(v) != model_rises(1, s, 20))
      begin bad++; $display("FAIL in_window_edge got=%0d exp=1", v); end
  endtask

  task automatic test_random();
    int s, d, g, e, prev0; logic [15:0] v; logic [3:0] v2;
    prev0 = -1;
    for (int it = 0; it < 4; it++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        ratio[ch] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(2, 20));
        lvl[ch]   = 1'($urandom_range(0, 1));
        ph[ch]    = int'($urandom_range(0, 19));
      end
      repeat (int'($urandom_range(1, 6))) step();
      g = int'($urandom_range(1, 300));
      launch(g, s);
      if (prev0 >= 0 && g > 2) begin
        read_ch(0, v, v2);
        total++; if (int'(v) != prev0) begin bad++; $display("FAIL rnd_hold got=%0d exp=%0d", v, prev0); end
      end
      wait_done(g + 20, d);
      total++; if (d != s + g + 1) begin bad++; $display("FAIL rnd_done_cycle got=%0d exp=%0d", d - s, g + 1); end
      for (int ch = 0; ch < NCH; ch++) begin
        read_ch(ch, v, v2);
        e = model_rises(ch, s, g);
        if (ch == 0) prev0 = e;
        total++; if (int'(v) != e) begin bad++; $display("FAIL rnd%0d_ch%0d got=%0d exp=%0d", it, ch, v, e); end
      end
      total++; if (overflow !== 10'd0) begin bad++; $display("FAIL rnd_ovf got=%b exp=0", overflow); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_channels();
    test_gate_zero();
    test_saturate();
    test_start_ignored();
    test_reset_abort();
    test_static();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
